// File: rtl/id_stage_hz_if.sv
// Decode-stage bundle: IF/ID inputs, writeback port, EX control, and the registered ID/EX outputs.
// Latency: none. This is a wiring bundle only.
// Backpressure: carries stallE/flushE in and stallD out. The slave side holds or bubbles ID/EX.
//
// Ports (by modport; "slave" is the decode stage):
//   ID in     : validD, instrD, PCD, PCPlus4D, ImmExtD, ctrlD, MemReadD, useRs1D, useRs2D
//   WB in     : weW, RdW, ResultW
//   EX ctl in : stallE, flushE
//   out       : stallD, validE, ctrlE, MemReadE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
//               RdE, Rs1E, Rs2E, funct3E
interface id_stage_hz_if #(
    parameter int XLEN   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16
);
    // IF/ID side
    logic              validD;
    logic [31:0]       instrD;
    logic [XLEN-1:0]   PCD;
    logic [XLEN-1:0]   PCPlus4D;
    logic [XLEN-1:0]   ImmExtD;
    logic [CTRL_W-1:0] ctrlD;
    logic              MemReadD;
    logic              useRs1D;
    logic              useRs2D;

    // writeback port into the register file
    logic              weW;
    logic [REG_AW-1:0] RdW;
    logic [XLEN-1:0]   ResultW;

    // EX-side control
    logic              stallE;
    logic              flushE;

    // outputs
    logic              stallD;
    logic              validE;
    logic [CTRL_W-1:0] ctrlE;
    logic              MemReadE;
    logic [XLEN-1:0]   RD1E;
    logic [XLEN-1:0]   RD2E;
    logic [XLEN-1:0]   PCE;
    logic [XLEN-1:0]   PCPlus4E;
    logic [XLEN-1:0]   ImmExtE;
    logic [REG_AW-1:0] RdE;
    logic [REG_AW-1:0] Rs1E;
    logic [REG_AW-1:0] Rs2E;
    logic [2:0]        funct3E;

    modport master (
        output validD, instrD, PCD, PCPlus4D, ImmExtD, ctrlD, MemReadD, useRs1D, useRs2D,
        output weW, RdW, ResultW,
        output stallE, flushE,
        input  stallD, validE, ctrlE, MemReadE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
        input  RdE, Rs1E, Rs2E, funct3E
    );

    modport slave (
        input  validD, instrD, PCD, PCPlus4D, ImmExtD, ctrlD, MemReadD, useRs1D, useRs2D,
        input  weW, RdW, ResultW,
        input  stallE, flushE,
        output stallD, validE, ctrlE, MemReadE, RD1E, RD2E, PCE, PCPlus4E, ImmExtE,
        output RdE, Rs1E, Rs2E, funct3E
    );
endinterface

// File: rtl/id_stage_hz.sv
// RV32I decode stage: register file, load-use hazard detect, ID/EX pipeline register.
// Latency: 1 cycle from ID inputs to the E outputs. stallD is combinational.
// Backpressure: stallE holds ID/EX and raises stallD. A load-use pair inserts one bubble. flushE wins over both.
//
// Ports:
//   clk    rising-edge clock
//   reset  synchronous, active-high; clears register file and ID/EX
//   bus    id_stage_hz_if.slave (ID inputs, writeback port, stallE/flushE in, stallD and E outputs)
//
// Build option: define RF_BYPASS_EN to make a same-cycle write and read of one nonzero
// register return ResultW (write-through). When it is not defined, the read sees the old value
// and EX forwarding has to cover that case.
module id_stage_hz #(
    parameter int XLEN   = 32,
    parameter int NREG   = 32,
    parameter int REG_AW = 5,
    parameter int CTRL_W = 16
) (
    input  logic          clk,
    input  logic          reset,
    id_stage_hz_if.slave  bus
);

    // ID/EX payload, kept as one packed word so that the hold and bubble paths stay uniform.
    typedef struct packed {
        logic              valid;
        logic [CTRL_W-1:0] ctrl;
        logic              mem_read;
        logic [XLEN-1:0]   rd1;
        logic [XLEN-1:0]   rd2;
        logic [XLEN-1:0]   pc;
        logic [XLEN-1:0]   pc_plus4;
        logic [XLEN-1:0]   imm;
        logic [REG_AW-1:0] rd;
        logic [REG_AW-1:0] rs1;
        logic [REG_AW-1:0] rs2;
        logic [2:0]        funct3;
    } idex_t;

    // ------------------------------------------------------------------
    // Instruction field extraction
    // ------------------------------------------------------------------
    logic [REG_AW-1:0] rs1_d;
    logic [REG_AW-1:0] rs2_d;
    logic [REG_AW-1:0] rd_d;
    logic [2:0]        funct3_d;

    assign rs1_d    = REG_AW'(bus.instrD[19:15]);
    assign rs2_d    = REG_AW'(bus.instrD[24:20]);
    assign rd_d     = REG_AW'(bus.instrD[11:7]);
    assign funct3_d = bus.instrD[14:12];

    // Opcode and funct7 are decoded upstream into ctrlD.
    logic unused_instr_bits;
    assign unused_instr_bits = ^{bus.instrD[31:25], bus.instrD[6:0]};

    // ------------------------------------------------------------------
    // Register file
    // ------------------------------------------------------------------
    logic [XLEN-1:0] rf [NREG];

    // A register index is "real" when it is nonzero and backed by storage.
    // x0 and out-of-range indices read as zero and absorb writes.
    function automatic logic idx_ok(input logic [REG_AW-1:0] idx);
        return (idx != '0) && (int'(idx) < NREG);
    endfunction

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NREG; i++) begin
                rf[i] <= '0;
            end
        end else if (bus.weW && idx_ok(bus.RdW)) begin
            rf[bus.RdW] <= bus.ResultW;
        end
    end

    logic [XLEN-1:0] rd1_d;
    logic [XLEN-1:0] rd2_d;

    always_comb begin
        rd1_d = '0;
        if (idx_ok(rs1_d)) begin
            rd1_d = rf[rs1_d];
`ifdef RF_BYPASS_EN
            if (bus.weW && (bus.RdW == rs1_d)) begin
                rd1_d = bus.ResultW;
            end
`endif
        end
    end

    always_comb begin
        rd2_d = '0;
        if (idx_ok(rs2_d)) begin
            rd2_d = rf[rs2_d];
`ifdef RF_BYPASS_EN
            if (bus.weW && (bus.RdW == rs2_d)) begin
                rd2_d = bus.ResultW;
            end
`endif
        end
    end

    // ------------------------------------------------------------------
    // Load-use hazard
    // ------------------------------------------------------------------
    idex_t idex_q;
    idex_t idex_d;
    logic  hz;
    logic  rs1_match;
    logic  rs2_match;

    assign rs1_match = bus.useRs1D && (idex_q.rd == rs1_d);
    assign rs2_match = bus.useRs2D && (idex_q.rd == rs2_d);

    // Compared against the ID/EX contents, so hz clears by itself once the bubble
    // has replaced the load in EX. Each load-use pair stalls for exactly one cycle.
    assign hz = idex_q.valid && idex_q.mem_read && (idex_q.rd != '0) &&
                bus.validD && (rs1_match || rs2_match);

    // The flush discards the instruction in ID, so the front end must not be held.
    assign bus.stallD = (hz || bus.stallE) && !bus.flushE;

    // ------------------------------------------------------------------
    // ID/EX register
    // ------------------------------------------------------------------
    always_comb begin
        idex_d          = '0;
        idex_d.valid    = bus.validD;
        // An empty IF/ID slot must not carry side effects into EX.
        idex_d.ctrl     = bus.validD ? bus.ctrlD : '0;
        idex_d.mem_read = bus.validD && bus.MemReadD;
        idex_d.rd1      = rd1_d;
        idex_d.rd2      = rd2_d;
        idex_d.pc       = bus.PCD;
        idex_d.pc_plus4 = bus.PCPlus4D;
        idex_d.imm      = bus.ImmExtD;
        idex_d.rd       = rd_d;
        idex_d.rs1      = rs1_d;
        idex_d.rs2      = rs2_d;
        idex_d.funct3   = funct3_d;
    end

    // Priority: reset, then flush, then EX hold, then hazard bubble, then normal load.
    // Bubbles are written as all-zero, so the data fields also read 0.
    always_ff @(posedge clk) begin
        if (reset) begin
            idex_q <= '0;
        end else if (bus.flushE) begin
            idex_q <= '0;
        end else if (bus.stallE) begin
            idex_q <= idex_q;
        end else if (hz) begin
            idex_q <= '0;
        end else begin
            idex_q <= idex_d;
        end
    end

    assign bus.validE   = idex_q.valid;
    assign bus.ctrlE    = idex_q.ctrl;
    assign bus.MemReadE = idex_q.mem_read;
    assign bus.RD1E     = idex_q.rd1;
    assign bus.RD2E     = idex_q.rd2;
    assign bus.PCE      = idex_q.pc;
    assign bus.PCPlus4E = idex_q.pc_plus4;
    assign bus.ImmExtE  = idex_q.imm;
    assign bus.RdE      = idex_q.rd;
    assign bus.Rs1E     = idex_q.rs1;
    assign bus.Rs2E     = idex_q.rs2;
    assign bus.funct3E  = idex_q.funct3;

endmodule

// File: tb/tb_id_stage_hz.sv
// Bench for id_stage_hz: reset, register readback, load-use stall, flush and hold priority,
// write-through behaviour. Vectors come from a table, and E-stage expectations pass through a scoreboard queue.
// Inputs are driven on the falling edge. stallD is sampled 1 time unit later, and E outputs on the next falling edge.
module tb_id_stage_hz;
    localparam int XLEN   = 32;
    localparam int NREG   = 32;
    localparam int REG_AW = 5;
    localparam int CTRL_W = 16;
    localparam logic [31:0] IMM_K = 32'h0F0F_0000;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    id_stage_hz_if #(.XLEN(XLEN), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) bus ();

    id_stage_hz #(.XLEN(XLEN), .NREG(NREG), .REG_AW(REG_AW), .CTRL_W(CTRL_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        logic        vld;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  f3;
        logic [31:0] pc;
        logic [15:0] ctrl;
        logic        mr;
        logic        u1;
        logic        u2;
        logic        we;
        logic [4:0]  wrd;
        logic [31:0] wdat;
        logic        stl;
        logic        fls;
    } in_t;

    typedef struct {
        logic        stall;
        logic        valid;
        logic [15:0] ctrl;
        logic        mr;
        logic        data;   // check operand/index/PC fields too (not for bubbles)
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [2:0]  f3;
        logic [31:0] rd1;
        logic [31:0] rd2;
        logic [31:0] pc;
    } exp_t;

    typedef struct {
        in_t  in;
        exp_t ex;
    } vec_t;

    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    int   sb_tag[$];

    task automatic chk(input string nm, input int tag, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s [vec %0d]: got %h, expected %h", nm, tag, act, exp);
        end
    endtask

    task automatic drive(input in_t v);
        bus.validD   = v.vld;
        bus.instrD   = {7'h00, v.rs2, v.rs1, v.f3, v.rd, 7'h33};
        bus.PCD      = v.pc;
        bus.PCPlus4D = v.pc + 32'd4;
        bus.ImmExtD  = v.pc ^ IMM_K;
        bus.ctrlD    = v.ctrl;
        bus.MemReadD = v.mr;
        bus.useRs1D  = v.u1;
        bus.useRs2D  = v.u2;
        bus.weW      = v.we;
        bus.RdW      = v.wrd;
        bus.ResultW  = v.wdat;
        bus.stallE   = v.stl;
        bus.flushE   = v.fls;
    endtask

    task automatic check_e();
        exp_t e;
        int   t;
        if (sb.size() == 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard: no expectation queued");
            return;
        end
        e = sb.pop_front();
        t = sb_tag.pop_front();
        chk("validE",   t, 32'(bus.validE),   32'(e.valid));
        chk("ctrlE",    t, 32'(bus.ctrlE),    32'(e.ctrl));
        chk("MemReadE", t, 32'(bus.MemReadE), 32'(e.mr));
        if (e.data) begin
            chk("Rs1E",     t, 32'(bus.Rs1E),    32'(e.rs1));
            chk("Rs2E",     t, 32'(bus.Rs2E),    32'(e.rs2));
            chk("RdE",      t, 32'(bus.RdE),     32'(e.rd));
            chk("funct3E",  t, 32'(bus.funct3E), 32'(e.f3));
            chk("RD1E",     t, bus.RD1E,         e.rd1);
            chk("RD2E",     t, bus.RD2E,         e.rd2);
            chk("PCE",      t, bus.PCE,          e.pc);
            chk("PCPlus4E", t, bus.PCPlus4E,     e.pc + 32'd4);
            chk("ImmExtE",  t, bus.ImmExtE,      e.pc ^ IMM_K);
        end
    endtask

    // Call on a falling edge; returns on the following falling edge.
    task automatic step(input in_t vi, input exp_t ve, input int tag);
        drive(vi);
        #1;
        chk("stallD", tag, 32'(bus.stallD), 32'(ve.stall));
        sb.push_back(ve);
        sb_tag.push_back(tag);
        @(posedge clk);
        @(negedge clk);
        check_e();
    endtask

    localparam in_t IDLE = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};

    vec_t tbl[17];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        in_t         iv;
        exp_t        ev;
        exp_t        hold_ex;
        logic [31:0] byp_val;
        int          wr_idx[9];
        logic [31:0] wr_val[9];

        // ---------------- reset ----------------
        reset = 1'b1;
        drive(IDLE);
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_validE",   0, 32'(bus.validE),   32'd0);
        chk("rst_ctrlE",    0, 32'(bus.ctrlE),    32'd0);
        chk("rst_MemReadE", 0, 32'(bus.MemReadE), 32'd0);
        chk("rst_stallD",   0, 32'(bus.stallD),   32'd0);
        reset = 1'b0;

        // ---------------- x1..x31 read back as zero ----------------
        for (int i = 1; i < 32; i++) begin
            iv = '{1, 0, 5'(i), 5'(32 - i), 0, 32'(i * 4), 0, 0, 1, 1, 0, 0, 0, 0, 0};
            ev = '{0, 1, 0, 0, 1, 5'(i), 5'(32 - i), 0, 0, 0, 0, 32'(i * 4)};
            step(iv, ev, 1000 + i);
        end

        // ---------------- fill registers through the writeback port ----------------
        // validD=0 with a nonzero control bundle and MemRead: these must enter EX as bubbles.
        wr_idx = '{1, 2, 3, 4, 5, 6, 7, 12, 0};
        for (int k = 0; k < 9; k++) begin
            wr_val[k] = (wr_idx[k] == 12) ? 32'h0000_1234 :
                        (wr_idx[k] == 0)  ? 32'h0000_0BAD : 32'h100 + 32'(wr_idx[k]);
            iv = '{0, 0, 0, 0, 0, 0, 16'hFFFF, 1, 1, 1, 1, 5'(wr_idx[k]), wr_val[k], 0, 0};
            ev = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
            step(iv, ev, 2000 + k);
        end

`ifdef RF_BYPASS_EN
        byp_val = 32'hDEAD_BEEF;
`else
        byp_val = 32'h0000_0103;
`endif

        // ---------------- vector table ----------------
        //               vld rd rs1 rs2 f3 pc     ctrl   mr u1 u2 we wrd wdat stl fls
        //               stall vld ctrl mr data rs1 rs2 rd f3 rd1 rd2 pc
        tbl[0]  = '{'{1, 4, 1, 2, 0, 'h40, 'h0011, 0, 1, 1, 0, 0, 0, 0, 0},
                    '{0, 1, 'h0011, 0, 1, 1, 2, 4, 0, 'h101, 'h102, 'h40}};
        tbl[1]  = '{'{1, 5, 3, 0, 2, 'h44, 'h0022, 1, 1, 0, 0, 0, 0, 0, 0},
                    '{0, 1, 'h0022, 1, 1, 3, 0, 5, 2, 'h103, 0, 'h44}};
        // lw x5 in EX and add x6,x5,x7 in ID: one stall cycle, then the add enters EX.
        tbl[2]  = '{'{1, 6, 5, 7, 0, 'h48, 'h0033, 0, 1, 1, 0, 0, 0, 0, 0},
                    '{1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        tbl[3]  = '{'{1, 6, 5, 7, 0, 'h48, 'h0033, 0, 1, 1, 0, 0, 0, 0, 0},
                    '{0, 1, 'h0033, 0, 1, 5, 7, 6, 0, 'h105, 'h107, 'h48}};
        // lw x0 followed by a reader of x0: no stall.
        tbl[4]  = '{'{1, 0, 1, 0, 2, 'h4C, 'h0044, 1, 1, 0, 0, 0, 0, 0, 0},
                    '{0, 1, 'h0044, 1, 1, 1, 0, 0, 2, 'h101, 0, 'h4C}};
        tbl[5]  = '{'{1, 8, 0, 0, 0, 'h50, 'h0055, 0, 1, 0, 0, 0, 0, 0, 0},
                    '{0, 1, 'h0055, 0, 1, 0, 0, 8, 0, 0, 0, 'h50}};
        // lw x5 followed by an instruction that has rs2=5 but does not use rs2: no stall.
        tbl[6]  = '{'{1, 5, 2, 0, 2, 'h54, 'h0066, 1, 1, 0, 0, 0, 0, 0, 0},
                    '{0, 1, 'h0066, 1, 1, 2, 0, 5, 2, 'h102, 0, 'h54}};
        tbl[7]  = '{'{1, 9, 1, 5, 4, 'h58, 'h0077, 0, 1, 0, 0, 0, 0, 0, 0},
                    '{0, 1, 'h0077, 0, 1, 1, 5, 9, 4, 'h101, 'h105, 'h58}};
        // Flush with a live hazard and stallE at the same time: flush wins.
        tbl[8]  = '{'{1, 5, 3, 0, 2, 'h5C, 'h0088, 1, 1, 0, 0, 0, 0, 0, 0},
                    '{0, 1, 'h0088, 1, 1, 3, 0, 5, 2, 'h103, 0, 'h5C}};
        tbl[9]  = '{'{1, 10, 5, 0, 0, 'h60, 'h0099, 0, 1, 0, 0, 0, 0, 1, 1},
                    '{0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0}};
        // Load RD1E=0x1234, then hold it with stallE for 3 cycles while ID changes.
        tbl[10] = '{'{1, 11, 12, 1, 1, 'h64, 'h00AA, 0, 1, 1, 0, 0, 0, 0, 0},
                    '{0, 1, 'h00AA, 0, 1, 12, 1, 11, 1, 'h1234, 'h101, 'h64}};
        hold_ex = tbl[10].ex;
        hold_ex.stall = 1'b1;
        tbl[11] = '{'{1, 13, 2, 3, 3, 'h68, 'h00BB, 1, 1, 1, 0, 0, 0, 1, 0}, hold_ex};
        tbl[12] = '{'{1, 14, 6, 4, 5, 'h6C, 'h00CC, 0, 1, 1, 0, 0, 0, 1, 0}, hold_ex};
        tbl[13] = '{'{0, 15, 7, 7, 6, 'h70, 'h00DD, 0, 0, 0, 0, 0, 0, 1, 0}, hold_ex};
        tbl[14] = '{'{1, 14, 3, 0, 0, 'h74, 'h00CC, 0, 1, 0, 0, 0, 0, 0, 0},
                    '{0, 1, 'h00CC, 0, 1, 3, 0, 14, 0, 'h103, 0, 'h74}};
        // Same-cycle write x3 and read x3.
        tbl[15] = '{'{1, 15, 3, 0, 0, 'h78, 'h00DD, 0, 1, 0, 1, 3, 'hDEADBEEF, 0, 0},
                    '{0, 1, 'h00DD, 0, 1, 3, 0, 15, 0, byp_val, 0, 'h78}};
        tbl[16] = '{'{1, 16, 3, 0, 0, 'h7C, 'h00EE, 0, 1, 0, 0, 0, 0, 0, 0},
                    '{0, 1, 'h00EE, 0, 1, 3, 0, 16, 0, 'hDEADBEEF, 0, 'h7C}};

        for (int v = 0; v < 17; v++) begin
            step(tbl[v].in, tbl[v].ex, v);
        end

        // ---------------- reset in the middle of a load-use stall ----------------
        iv = '{1, 5, 1, 0, 2, 'h80, 'h0011, 1, 1, 0, 0, 0, 0, 0, 0};
        ev = '{0, 1, 'h0011, 1, 1, 1, 0, 5, 2, 'h101, 0, 'h80};
        step(iv, ev, 100);
        iv = '{1, 6, 5, 0, 0, 'h84, 'h0022, 0, 1, 0, 0, 0, 0, 0, 0};
        drive(iv);
        #1;
        chk("midstall_stallD", 101, 32'(bus.stallD), 32'd1);
        reset = 1'b1;
        @(posedge clk);
        @(negedge clk);
        chk("postrst_validE",   101, 32'(bus.validE),   32'd0);
        chk("postrst_MemReadE", 101, 32'(bus.MemReadE), 32'd0);
        chk("postrst_stallD",   101, 32'(bus.stallD),   32'd0);
        reset = 1'b0;
        // The register file was cleared as well.
        iv = '{1, 7, 1, 0, 0, 'h88, 'h0033, 0, 1, 0, 0, 0, 0, 0, 0};
        ev = '{0, 1, 'h0033, 0, 1, 1, 0, 7, 0, 0, 0, 'h88};
        step(iv, ev, 102);

        drive(IDLE);
        @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
